multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the ri5cy frontend. It fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake and holds it in an instruction register. It drives that register into the combinational instruction decoder, then sequences execute and writeback enables for the ALU and register file. It also owns the program counter and halts on an illegal instruction.

---
 rtl/multicycle_sequencer_pkg.sv | 18 +
 rtl/multicycle_sequencer_if.sv | 29 ++
 rtl/multicycle_sequencer_pc_counter.sv | 23 ++
 rtl/multicycle_sequencer.sv | 105 ++++++++++
 tb/tb_multicycle_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer:
// controller states, word width, boot address and PC step.
package riscv_defines;

    localparam int          WORD_WIDTH = 32;
    localparam logic [31:0] BOOT_ADDR  = 32'h0000_0080;
    localparam logic [31:0] PC_INCR    = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        WB,
        TRAP
    } ctrl_state_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction-memory request/grant/rvalid bus.
// The sequencer is the master, the memory is the slave.
interface multicycle_sequencer_if #(
    parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) ();

    logic                  instr_req_o;
    logic [WORD_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [WORD_WIDTH-1:0] instr_rdata_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i
    );

endinterface

// File: rtl/multicycle_sequencer_pc_counter.sv
// Program counter: loads the boot address on reset and
// advances by one instruction word when enabled.
module pc_counter #(
    parameter int                    WORD_WIDTH = riscv_defines::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = riscv_defines::BOOT_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_en,
    output logic [WORD_WIDTH-1:0] pc
);
    import riscv_defines::*;

    // PC register; the add wraps naturally at the word boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= BOOT_ADDR;
        end else if (inc_en) begin
            pc <= pc + WORD_WIDTH'(PC_INCR);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/execute/writeback sequencer with an
// instruction register, PC ownership and illegal-instruction halt.
module multicycle_sequencer #(
    parameter int                    WORD_WIDTH = riscv_defines::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = riscv_defines::BOOT_ADDR
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fetch_en_i,
    multicycle_sequencer_if.master bus,
    output logic [WORD_WIDTH-1:0]  instr_o,
    input  logic                   illegal_instr_i,
    input  logic                   regwrite_en_i,
    output logic                   alu_en_o,
    output logic                   rf_we_o,
    output logic                   retire_o,
    output logic                   halted_o
);
    import riscv_defines::*;

    ctrl_state_t           state_q;
    ctrl_state_t           state_d;
    logic [WORD_WIDTH-1:0] instr_q;
    logic [WORD_WIDTH-1:0] pc;
    logic                  pc_inc;

    pc_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .BOOT_ADDR  (BOOT_ADDR)
    ) u_pc (
        .clk    (clk_i),
        .rst    (rst_i),
        .inc_en (pc_inc),
        .pc     (pc)
    );

    // State register; reset also drops any outstanding request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fetch_en_i only matters in IDLE, WB and TRAP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i) state_d = FETCH;
            end
            FETCH: begin
                if (bus.instr_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.instr_rvalid_i) state_d = EXEC;
            end
            EXEC: begin
                state_d = illegal_instr_i ? TRAP : WB;
            end
            WB: begin
                state_d = fetch_en_i ? FETCH : IDLE;
            end
            TRAP: begin
                if (!fetch_en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state and registered values
    always_comb begin
        bus.instr_req_o = 1'b0;
        alu_en_o        = 1'b0;
        rf_we_o         = 1'b0;
        retire_o        = 1'b0;
        halted_o        = 1'b0;
        pc_inc          = 1'b0;
        unique case (state_q)
            FETCH: bus.instr_req_o = 1'b1;
            EXEC:  alu_en_o        = 1'b1;
            WB: begin
                rf_we_o  = regwrite_en_i;
                retire_o = 1'b1;
                pc_inc   = 1'b1;
            end
            TRAP:  halted_o        = 1'b1;
            default: ;
        endcase
    end

    assign bus.instr_addr_o = pc;
    assign instr_o          = instr_q;

    // Instruction register; loads only when the read data returns
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= '0;
        end else if (state_q == WAIT && bus.instr_rvalid_i) begin
            instr_q <= bus.instr_rdata_i;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus queues
// expected fetches/retires, a monitor pops them as the DUT emits.
module tb_multicycle_sequencer;

    typedef struct {
        logic        we;
        logic [31:0] instr;
    } ret_t;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] instr;
    logic        illegal;
    logic        regwrite;
    logic        alu_en;
    logic        rf_we;
    logic        retire;
    logic        halted;

    logic [31:0] instr2;
    logic        illegal2;
    logic        regwrite2;
    logic        alu_en2;
    logic        rf_we2;
    logic        retire2;
    logic        halted2;

    logic        resp_en;
    logic        resp_gnt;
    logic        resp_rvalid;
    logic        man_gnt;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    logic [31:0] mem_word;
    int          gnt_stall;
    int          stall_cnt;
    logic        pend;

    int          n_vec;
    int          n_err;
    int          cyc;

    logic [31:0] exp_addr[$];
    ret_t        exp_ret[$];
    int          req_cycs[$];
    int          req_lens[$];
    int          alu_cycs[$];
    int          ret_cycs[$];
    int          halt_cycs[$];
    logic [31:0] d2_addrs[$];

    multicycle_sequencer_if #(.WORD_WIDTH(32)) bus ();
    multicycle_sequencer_if #(.WORD_WIDTH(32)) bus2 ();

    assign bus.instr_gnt_i     = resp_en ? resp_gnt : man_gnt;
    assign bus.instr_rvalid_i  = resp_en ? resp_rvalid : man_rvalid;
    assign bus.instr_rdata_i   = resp_en ? mem_word : man_rdata;
    assign bus2.instr_gnt_i    = bus.instr_gnt_i;
    assign bus2.instr_rvalid_i = bus.instr_rvalid_i;
    assign bus2.instr_rdata_i  = bus.instr_rdata_i;

    // Stand-in decoder: all-ones is illegal, OP/OP-IMM write rd
    assign illegal   = (instr == 32'hFFFF_FFFF);
    assign regwrite  = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h13);
    assign illegal2  = (instr2 == 32'hFFFF_FFFF);
    assign regwrite2 = (instr2[6:0] == 7'h33) || (instr2[6:0] == 7'h13);

    multicycle_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .fetch_en_i      (fetch_en),
        .bus             (bus),
        .instr_o         (instr),
        .illegal_instr_i (illegal),
        .regwrite_en_i   (regwrite),
        .alu_en_o        (alu_en),
        .rf_we_o         (rf_we),
        .retire_o        (retire),
        .halted_o        (halted)
    );

    multicycle_sequencer #(
        .WORD_WIDTH (32),
        .BOOT_ADDR  (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk_i           (clk),
        .rst_i           (rst),
        .fetch_en_i      (fetch_en),
        .bus             (bus2),
        .instr_o         (instr2),
        .illegal_instr_i (illegal2),
        .regwrite_en_i   (regwrite2),
        .alu_en_o        (alu_en2),
        .rf_we_o         (rf_we2),
        .retire_o        (retire2),
        .halted_o        (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Memory model: grant after gnt_stall cycles, data the next cycle
    initial begin
        resp_gnt    = 1'b0;
        resp_rvalid = 1'b0;
        stall_cnt   = 0;
        pend        = 1'b0;
        forever begin
            @(negedge clk);
            resp_gnt    = 1'b0;
            resp_rvalid = 1'b0;
            if (rst) begin
                stall_cnt = 0;
                pend      = 1'b0;
            end else if (bus.instr_req_o) begin
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    resp_gnt  = 1'b1;
                    stall_cnt = 0;
                    pend      = 1'b1;
                end
            end else if (pend) begin
                resp_rvalid = 1'b1;
                pend        = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        logic        prev_req;
        logic        prev_halt;
        logic [31:0] prev_addr;
        int          req_start;
        ret_t        e;
        prev_req  = 1'b0;
        prev_halt = 1'b0;
        prev_addr = '0;
        req_start = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req  = 1'b0;
                prev_halt = 1'b0;
            end else begin
                if (bus.instr_req_o && !prev_req) begin
                    req_cycs.push_back(cyc);
                    req_start = cyc;
                    if (exp_addr.size() == 0) flag("unexpected_req");
                    else chk("fetch_addr", bus.instr_addr_o,
                             exp_addr.pop_front());
                end
                if (bus.instr_req_o && prev_req)
                    chk("addr_hold", bus.instr_addr_o, prev_addr);
                if (!bus.instr_req_o && prev_req)
                    req_lens.push_back(cyc - req_start);
                if (alu_en) alu_cycs.push_back(cyc);
                if (rf_we && !retire) flag("rf_we_without_retire");
                if (retire) begin
                    ret_cycs.push_back(cyc);
                    if (exp_ret.size() == 0) begin
                        flag("unexpected_retire");
                    end else begin
                        e = exp_ret.pop_front();
                        chk("rf_we", 32'(rf_we), 32'(e.we));
                        chk("retire_instr", instr, e.instr);
                    end
                end
                if (halted && !prev_halt) halt_cycs.push_back(cyc);
                prev_req  = bus.instr_req_o;
                prev_halt = halted;
                prev_addr = bus.instr_addr_o;
            end
        end
    end

    // Wrap-instance monitor: record each fetch address
    initial begin
        logic prev2;
        prev2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev2 = 1'b0;
            end else begin
                if (bus2.instr_req_o && !prev2)
                    d2_addrs.push_back(bus2.instr_addr_o);
                prev2 = bus2.instr_req_o;
            end
        end
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return req_cycs.size();
            1:       return ret_cycs.size();
            2:       return halt_cycs.size();
            default: return req_lens.size();
        endcase
    endfunction

    task automatic wait_cnt(input string nm, input int which,
                            input int n);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (qsize(which) >= n) return;
        end
        flag({nm, "_timeout"});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst      = 1'b1;
        fetch_en = 1'b0;
        exp_addr.delete();
        exp_ret.delete();
        req_cycs.delete();
        req_lens.delete();
        alu_cycs.delete();
        ret_cycs.delete();
        halt_cycs.delete();
        d2_addrs.delete();
        idle(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(bus.instr_req_o), 32'h0);
        chk({tag, "_addr"}, bus.instr_addr_o, 32'h0000_0080);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_alu_en"}, 32'(alu_en), 32'h0);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'h0);
        chk({tag, "_retire"}, 32'(retire), 32'h0);
        chk({tag, "_halted"}, 32'(halted), 32'h0);
        chk({tag, "_wrap_addr"}, bus2.instr_addr_o, 32'hFFFF_FFFC);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_exp_addr_left"}, 32'(exp_addr.size()), 32'h0);
        chk({tag, "_exp_ret_left"}, 32'(exp_ret.size()), 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ret_t r;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        rst        = 1'b1;
        fetch_en   = 1'b0;
        resp_en    = 1'b1;
        man_gnt    = 1'b0;
        man_rvalid = 1'b0;
        man_rdata  = '0;
        mem_word   = '0;
        gnt_stall  = 0;

        // Reset values
        idle(2);
        chk_reset_outputs("reset");

        // Zero-wait fetch of add, back-to-back with the next word
        do_reset();
        mem_word = 32'h0031_00B3;
        exp_addr.push_back(32'h0000_0080);
        exp_addr.push_back(32'h0000_0084);
        r.we = 1'b1; r.instr = 32'h0031_00B3;
        exp_ret.push_back(r);
        exp_ret.push_back(r);
        fetch_en = 1'b1;
        wait_cnt("t1_req2", 0, 2);
        fetch_en = 1'b0;
        wait_cnt("t1_ret2", 1, 2);
        idle(8);
        chk("t1_alu_after_req", 32'(alu_cycs[0] - req_cycs[0]), 32'd2);
        chk("t1_ret_after_alu", 32'(ret_cycs[0] - alu_cycs[0]), 32'd1);
        chk("t1_req_spacing", 32'(req_cycs[1] - req_cycs[0]), 32'd4);
        chk("t1_req_count", 32'(req_cycs.size()), 32'd2);
        chk("t1_wrap_first", d2_addrs[0], 32'hFFFF_FFFC);
        chk("t1_wrap_next", d2_addrs[1], 32'h0000_0000);
        chk_drained("t1");

        // Grant held off for 3 cycles
        do_reset();
        gnt_stall = 3;
        mem_word  = 32'h4020_8133;
        exp_addr.push_back(32'h0000_0080);
        r.we = 1'b1; r.instr = 32'h4020_8133;
        exp_ret.push_back(r);
        fetch_en = 1'b1;
        wait_cnt("t2_req", 0, 1);
        fetch_en = 1'b0;
        wait_cnt("t2_ret", 1, 1);
        idle(6);
        gnt_stall = 0;
        chk("t2_req_len", 32'(req_lens[0]), 32'd4);
        chk("t2_retire_cycle", 32'(ret_cycs[0] - req_cycs[0] + 1), 32'd7);
        chk("t2_req_count", 32'(req_cycs.size()), 32'd1);
        chk_drained("t2");

        // Illegal instruction halts, then recovers at the same PC
        do_reset();
        mem_word = 32'hFFFF_FFFF;
        exp_addr.push_back(32'h0000_0080);
        fetch_en = 1'b1;
        wait_cnt("t3_halt", 2, 1);
        idle(3);
        chk("t3_halt_cycle", 32'(halt_cycs[0] - alu_cycs[0]), 32'd1);
        chk("t3_halted_held", 32'(halted), 32'h1);
        chk("t3_no_req", 32'(bus.instr_req_o), 32'h0);
        chk("t3_no_retire", 32'(ret_cycs.size()), 32'h0);
        chk("t3_pc_kept", bus.instr_addr_o, 32'h0000_0080);
        fetch_en = 1'b0;
        idle(1);
        chk("t3_left_trap", 32'(halted), 32'h0);
        mem_word = 32'h0031_00B3;
        exp_addr.push_back(32'h0000_0080);
        r.we = 1'b1; r.instr = 32'h0031_00B3;
        exp_ret.push_back(r);
        fetch_en = 1'b1;
        wait_cnt("t3_refetch", 0, 2);
        fetch_en = 1'b0;
        wait_cnt("t3_ret", 1, 1);
        idle(6);
        chk_drained("t3");

        // Enable dropped while waiting for data; store has no writeback
        do_reset();
        mem_word = 32'h0020_A023;
        exp_addr.push_back(32'h0000_0080);
        r.we = 1'b0; r.instr = 32'h0020_A023;
        exp_ret.push_back(r);
        fetch_en = 1'b1;
        wait_cnt("t4_wait", 3, 1);
        fetch_en = 1'b0;
        wait_cnt("t4_ret", 1, 1);
        idle(10);
        chk("t4_req_count", 32'(req_cycs.size()), 32'd1);
        chk("t4_pc_next", bus.instr_addr_o, 32'h0000_0084);
        chk_drained("t4");

        // Reset in WAIT, then a stale rvalid after release
        do_reset();
        resp_en = 1'b0;
        exp_addr.push_back(32'h0000_0080);
        fetch_en = 1'b1;
        wait_cnt("t6_req", 0, 1);
        man_gnt = 1'b1;
        idle(1);
        man_gnt = 1'b0;
        chk("t6_in_wait_req", 32'(bus.instr_req_o), 32'h0);
        fetch_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_mid_reset");
        idle(1);
        rst = 1'b0;
        idle(1);
        man_rvalid = 1'b1;
        man_rdata  = 32'h0031_00B3;
        idle(1);
        man_rvalid = 1'b0;
        idle(4);
        chk("t6_no_exec", 32'(alu_cycs.size()), 32'h0);
        chk("t6_instr_clear", instr, 32'h0);
        chk("t6_no_retire", 32'(ret_cycs.size()), 32'h0);
        chk_drained("t6");
        resp_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
